eth_tx_arbiter: RTL and testbench
=================================

# eth_tx_arbiter

Transmit-side counterpart of the receive demultiplexer. Shares the single 8-bit MAC TX AXI-Stream between the ARP reply engine and the IP/UDP transmit engine. Arbitrates at frame granularity and prepends the 14-byte Ethernet header (destination MAC, local source MAC, EtherType) to each granted payload. Optionally pads short payloads to the Ethernet minimum.

## Interface
Parameters:
- MIN_PAYLOAD, 46: minimum payload byte count; used only when padding is compiled in.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- local_mac_addr_in  in  48  source MAC inserted in every header
- arp_dst_mac_in  in  48  destination MAC for ARP frames; sampled at grant
- arp_axis_tdata_in  in  8  ARP payload byte
- arp_axis_tvalid_in  in  1  ARP byte valid; asserted in IDLE, it is a frame request
- arp_axis_tlast_in  in  1  last ARP payload byte
- arp_axis_tready_o  out  1  ARP byte accepted
- ip_dst_mac_in  in  48  destination MAC for IP frames; sampled at grant
- ip_axis_tdata_in / ip_axis_tvalid_in / ip_axis_tlast_in  in  8/1/1  IP payload stream
- ip_axis_tready_o  out  1  IP byte accepted
- tx_axis_tdata_out  out  8  frame byte to MAC
- tx_axis_tvalid_out  out  1  frame byte valid
- tx_axis_tlast_out  out  1  last frame byte
- tx_axis_tready_in  in  1  MAC ready
- grant_o  out  2  {ip, arp} one-hot owner of the current frame; 0 when idle

## Operation
- States: IDLE, HDR, PAYLOAD, PAD (PAD exists only with the macro).
- IDLE:
  - If any source tvalid is high, grant one source. Round-robin: the source not served last wins a tie; ARP wins the first tie after reset.
  - Latch the granted dst MAC.
  - Set EtherType to 16'h0806 (ARP) or 16'h0800 (IP).
  - hdr_cnt <= 0; go to HDR.
- HDR:
  - tvalid_out=1, tlast_out=0.
  - Bytes in order, MSB first: dst MAC[47:40]..[7:0], local_mac_addr_in[47:40]..[7:0], EtherType[15:8], [7:0].
  - hdr_cnt advances only on a handshake (tvalid_out && tready_in).
  - After byte 13 is accepted: pay_cnt <= 0; go to PAYLOAD.
- PAYLOAD:
  - tdata_out, tvalid_out, tlast_out pass combinationally from the granted source.
  - Granted source tready_o = tx_axis_tready_in.
  - Non-granted source tready_o = 0 in every state.
  - pay_cnt (16-bit, saturating at 16'hFFFF) increments on each handshake.
  - On the handshake of a source byte with tlast: go to IDLE and record the last-served source.
- grant_o holds its value from HDR through the end of the frame; it is 0 in IDLE.
- Source changes to dst_mac_in after grant have no effect on the current frame.
- Reset mid-frame: on the next cycle, state=IDLE, all outputs return to reset values, and the frame is truncated without tlast. The receiving MAC must discard it.
- Reset values: tx_axis_tdata_out=0, tx_axis_tvalid_out=0, tx_axis_tlast_out=0, arp/ip tready_o=0, grant_o=0, last-served=IP (so ARP wins the first tie).

## Timing
- Request to first header byte: 1 cycle (IDLE registers the grant; byte 0 appears the next cycle).
- Header: 14 cycles minimum; one extra cycle for each cycle tready_in is low.
- Payload: zero-latency pass-through; no added bubbles.
- Back-to-back frames: one idle cycle (tvalid_out=0) between the last byte of a frame and byte 0 of the next header.
- tready_in low: all counters, state and output data hold. tvalid_out and tdata_out stay stable in HDR/PAD; in PAYLOAD they follow the source.
- A source that drops tvalid mid-payload stalls the frame. tvalid_out=0 for that time; the grant is kept.

## Configuration
- TX_ARB_PAD_EN defined:
  - In PAYLOAD, a source tlast with pay_cnt+1 < MIN_PAYLOAD is accepted but not forwarded (tlast_out=0); go to PAD.
  - PAD drives tdata=0, tvalid=1, and counts handshakes until pay_cnt = MIN_PAYLOAD.
  - tlast_out=1 on the final pad byte, then go to IDLE.
  - A source tready_o is 0 during PAD.
- TX_ARB_PAD_EN undefined: PAD state and the comparison logic are absent. The source tlast is always forwarded; frames may be shorter than 60 bytes.

## Test plan
- ARP only, dst=FF..FF, local=00_0A_35_01_02_03, 28-byte payload, tready=1 -> bytes FF×6, 00 0A 35 01 02 03, 08 06, payload. Without the macro, tlast is on byte 42; with the macro, 18 zero bytes follow and tlast is on byte 60.
- ARP and IP both requesting in the same cycle after reset -> ARP frame first (EtherType 08 06), one idle cycle, then IP frame (08 00); grant_o goes 01 -> 00 -> 10.
- IP requesting continuously with 2 ARP requests pending -> frames alternate IP/ARP; no source gets two frames in a row while the other is waiting.
- tready_in toggled every other cycle for a 100-byte IP payload -> output sequence identical to the tready=1 run, with tdata held stable while tready is low.
- 1-byte payload 0xAB with tlast -> no macro: 15-byte frame, tlast on 0xAB. Macro with MIN_PAYLOAD=46: 0xAB followed by 45 zeros, tlast on the last zero, 60 bytes total.
- Reset asserted for 1 cycle during header byte 7 -> next cycle tvalid_out=0, grant_o=0. A subsequent request produces a full new header starting from byte 0.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Shares the single 8-bit MAC TX AXI-Stream between the ARP reply engine and
// the IP/UDP transmit engine. Whole frames are granted round-robin. Each
// granted payload gets a 14-byte Ethernet header in front of it: the
// destination MAC, then local_mac_addr_in, then the EtherType.
//
// Optional feature: define TX_ARB_PAD_EN to zero-pad payloads shorter than
// MIN_PAYLOAD bytes. The default build has no padding logic, so short frames
// go out unpadded.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   local_mac_addr_in     source MAC placed in every header
//   arp_dst_mac_in        ARP destination MAC, sampled at grant
//   arp_axis_t*           ARP payload stream (tdata/tvalid/tlast in, tready out)
//   ip_dst_mac_in         IP destination MAC, sampled at grant
//   ip_axis_t*            IP payload stream (tdata/tvalid/tlast in, tready out)
//   tx_axis_t*            frame stream to the MAC (tdata/tvalid/tlast out, tready in)
//   grant_o               {ip, arp} one-hot owner of the current frame, 0 when idle
module eth_tx_arbiter #(
    parameter int unsigned MIN_PAYLOAD = 46
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] local_mac_addr_in,
    input  logic [47:0] arp_dst_mac_in,
    input  logic [7:0]  arp_axis_tdata_in,
    input  logic        arp_axis_tvalid_in,
    input  logic        arp_axis_tlast_in,
    output logic        arp_axis_tready_o,
    input  logic [47:0] ip_dst_mac_in,
    input  logic [7:0]  ip_axis_tdata_in,
    input  logic        ip_axis_tvalid_in,
    input  logic        ip_axis_tlast_in,
    output logic        ip_axis_tready_o,
    output logic [7:0]  tx_axis_tdata_out,
    output logic        tx_axis_tvalid_out,
    output logic        tx_axis_tlast_out,
    input  logic        tx_axis_tready_in,
    output logic [1:0]  grant_o
);

    // pay_cnt is 16 bits wide, so it can never reach a larger pad target.
    if (MIN_PAYLOAD > 65535) begin : g_min_payload_range
        $error("eth_tx_arbiter: MIN_PAYLOAD exceeds the 16-bit payload counter");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD
`ifdef TX_ARB_PAD_EN
        , S_PAD
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_ip_q, last_ip_d;   // 1: the last frame served came from IP
    logic [47:0] dst_q, dst_d;
    logic [15:0] etype_q, etype_d;
    logic [3:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;

    logic [111:0] hdr_vec;
    logic [3:0]   hdr_idx;
    logic [7:0]   hdr_byte;
    logic         sel_ip;
    logic [7:0]   src_tdata;
    logic         src_tvalid;
    logic         src_tlast;
    logic         pick_ip;
    logic [15:0]  pay_cnt_inc;

    // The header is stored as one 112-bit word. Byte hdr_cnt is taken from
    // the top end, so it goes out MSB first.
    assign hdr_vec  = {dst_q, local_mac_addr_in, etype_q};
    assign hdr_idx  = 4'd13 - hdr_cnt_q;
    assign hdr_byte = hdr_vec[{hdr_idx, 3'b000} +: 8];

    assign sel_ip     = grant_q[1];
    assign src_tdata  = sel_ip ? ip_axis_tdata_in  : arp_axis_tdata_in;
    assign src_tvalid = sel_ip ? ip_axis_tvalid_in : arp_axis_tvalid_in;
    assign src_tlast  = sel_ip ? ip_axis_tlast_in  : arp_axis_tlast_in;

    // IP wins when it is the only requester, or on a tie when ARP was served last.
    assign pick_ip     = ip_axis_tvalid_in && (!arp_axis_tvalid_in || !last_ip_q);
    assign pay_cnt_inc = (pay_cnt_q == '1) ? pay_cnt_q : pay_cnt_q + 16'd1;

`ifdef TX_ARB_PAD_EN
    logic [16:0] pay_cnt_p1;
    assign pay_cnt_p1 = {1'b0, pay_cnt_q} + 17'd1;
`endif

    assign grant_o = grant_q;

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        last_ip_d          = last_ip_q;
        dst_d              = dst_q;
        etype_d            = etype_q;
        hdr_cnt_d          = hdr_cnt_q;
        pay_cnt_d          = pay_cnt_q;
        tx_axis_tdata_out  = '0;
        tx_axis_tvalid_out = 1'b0;
        tx_axis_tlast_out  = 1'b0;
        arp_axis_tready_o  = 1'b0;
        ip_axis_tready_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (arp_axis_tvalid_in || ip_axis_tvalid_in) begin
                    grant_d   = pick_ip ? 2'b10 : 2'b01;
                    dst_d     = pick_ip ? ip_dst_mac_in : arp_dst_mac_in;
                    etype_d   = pick_ip ? 16'h0800 : 16'h0806;
                    hdr_cnt_d = '0;
                    state_d   = S_HDR;
                end
            end

            S_HDR: begin
                tx_axis_tvalid_out = 1'b1;
                tx_axis_tdata_out  = hdr_byte;
                if (tx_axis_tready_in) begin
                    if (hdr_cnt_q == 4'd13) begin
                        pay_cnt_d = '0;
                        state_d   = S_PAYLOAD;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 4'd1;
                    end
                end
            end

            S_PAYLOAD: begin
                tx_axis_tdata_out  = src_tdata;
                tx_axis_tvalid_out = src_tvalid;
                tx_axis_tlast_out  = src_tlast;
                arp_axis_tready_o  = !sel_ip && tx_axis_tready_in;
                ip_axis_tready_o   = sel_ip && tx_axis_tready_in;
                if (src_tvalid && tx_axis_tready_in) begin
                    pay_cnt_d = pay_cnt_inc;
                    if (src_tlast) begin
`ifdef TX_ARB_PAD_EN
                        // A short payload keeps its last byte on the wire.
                        // Only tlast moves to the final pad byte.
                        if (pay_cnt_p1 < 17'(MIN_PAYLOAD)) begin
                            tx_axis_tlast_out = 1'b0;
                            state_d           = S_PAD;
                        end else begin
                            state_d   = S_IDLE;
                            grant_d   = '0;
                            last_ip_d = sel_ip;
                        end
`else
                        state_d   = S_IDLE;
                        grant_d   = '0;
                        last_ip_d = sel_ip;
`endif
                    end
                end
            end

`ifdef TX_ARB_PAD_EN
            S_PAD: begin
                tx_axis_tvalid_out = 1'b1;
                tx_axis_tlast_out  = (pay_cnt_p1 >= 17'(MIN_PAYLOAD));
                if (tx_axis_tready_in) begin
                    pay_cnt_d = pay_cnt_inc;
                    if (pay_cnt_p1 >= 17'(MIN_PAYLOAD)) begin
                        state_d   = S_IDLE;
                        grant_d   = '0;
                        last_ip_d = sel_ip;
                    end
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_ip_q <= 1'b1;
            dst_q     <= '0;
            etype_q   <= '0;
            hdr_cnt_q <= '0;
            pay_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_ip_q <= last_ip_d;
            dst_q     <= dst_d;
            etype_q   <= etype_d;
            hdr_cnt_q <= hdr_cnt_d;
            pay_cnt_q <= pay_cnt_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
`timescale 1ns/1ps
module tb_eth_tx_arbiter;

    localparam logic [47:0] LOCAL_MAC = 48'h000A35010203;
    localparam int MIN_PAY = 46;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] local_mac, arp_dst, ip_dst;
    logic [7:0]  arp_tdata, ip_tdata, tx_tdata;
    logic        arp_tvalid, arp_tlast, arp_tready;
    logic        ip_tvalid, ip_tlast, ip_tready;
    logic        tx_tvalid, tx_tlast, tx_tready;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    eth_tx_arbiter #(.MIN_PAYLOAD(MIN_PAY)) dut (
        .clk(clk), .reset(reset),
        .local_mac_addr_in(local_mac),
        .arp_dst_mac_in(arp_dst),
        .arp_axis_tdata_in(arp_tdata), .arp_axis_tvalid_in(arp_tvalid),
        .arp_axis_tlast_in(arp_tlast), .arp_axis_tready_o(arp_tready),
        .ip_dst_mac_in(ip_dst),
        .ip_axis_tdata_in(ip_tdata), .ip_axis_tvalid_in(ip_tvalid),
        .ip_axis_tlast_in(ip_tlast), .ip_axis_tready_o(ip_tready),
        .tx_axis_tdata_out(tx_tdata), .tx_axis_tvalid_out(tx_tvalid),
        .tx_axis_tlast_out(tx_tlast), .tx_axis_tready_in(tx_tready),
        .grant_o(grant)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [1:0] grant;
        int         cyc;
    } beat_t;

    typedef struct {
        bit          ip;
        logic [47:0] dst;
        int          len;
        logic [7:0]  seed;
        int          mode;       // 0: tready=1, 1: toggling, 2: random
        int          exp_len;    // frame bytes without padding
        int          exp_len_pad;
        logic [15:0] etype;
    } vec_t;

    beat_t      cap_q[$], exp_q[$];
    logic [8:0] arp_src[$], ip_src[$];
    logic       log_v[$];
    logic [1:0] log_g[$];
    vec_t       vecs[7];

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, tr_mode = 0, frame_pos = 0, load_cyc = 0;
    logic stall_chk = 1'b0;
    logic [7:0] stall_data = '0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_src();
        if (arp_src.size() > 0) begin
            arp_tvalid = 1'b1; arp_tdata = arp_src[0][7:0]; arp_tlast = arp_src[0][8];
        end else begin
            arp_tvalid = 1'b0; arp_tdata = '0; arp_tlast = 1'b0;
        end
        if (ip_src.size() > 0) begin
            ip_tvalid = 1'b1; ip_tdata = ip_src[0][7:0]; ip_tlast = ip_src[0][8];
        end else begin
            ip_tvalid = 1'b0; ip_tdata = '0; ip_tlast = 1'b0;
        end
    endtask

    // One clock: sample at the negedge, advance sources just after the posedge.
    task automatic step();
        bit arp_hs, ip_hs;
        @(negedge clk);
        if (stall_chk && !reset)
            check(tx_tvalid === 1'b1 && tx_tdata === stall_data, "hdr_stall_hold",
                  {tx_tvalid, tx_tdata}, {1'b1, stall_data});
        stall_chk  = tx_tvalid && !tx_tready && frame_pos < 14 && !reset;
        stall_data = tx_tdata;
        log_v.push_back(tx_tvalid);
        log_g.push_back(grant);
        arp_hs = !reset && arp_tvalid && arp_tready;
        ip_hs  = !reset && ip_tvalid && ip_tready;
        if (!reset && tx_tvalid && tx_tready) begin
            cap_q.push_back('{tx_tdata, tx_tlast, grant, cyc});
            frame_pos = tx_tlast ? 0 : frame_pos + 1;
        end
        if (reset) frame_pos = 0;
        @(posedge clk);
        #1;
        cyc++;
        if (arp_hs && arp_src.size() > 0) void'(arp_src.pop_front());
        if (ip_hs && ip_src.size() > 0) void'(ip_src.pop_front());
        case (tr_mode)
            0:       tx_tready = 1'b1;
            1:       tx_tready = cyc[0];
            default: tx_tready = ($urandom_range(0, 3) != 0);
        endcase
        drive_src();
    endtask

    // Queue one payload on a source and append the expected frame; returns its length.
    function automatic int add_frame(input bit ip, input logic [47:0] dst, input int len, input logic [7:0] seed);
        logic [15:0] et;
        logic [7:0]  e;
        logic [1:0]  g;
        int          pay, n;
        et  = ip ? 16'h0800 : 16'h0806;
        g   = ip ? 2'b10 : 2'b01;
        pay = len;
`ifdef TX_ARB_PAD_EN
        if (len < MIN_PAY) pay = MIN_PAY;
`endif
        n = 14 + pay;
        for (int i = 0; i < n; i++) begin
            if (i < 6)             e = dst[47 - 8*i -: 8];
            else if (i < 12)       e = LOCAL_MAC[47 - 8*(i-6) -: 8];
            else if (i == 12)      e = et[15:8];
            else if (i == 13)      e = et[7:0];
            else if (i < 14 + len) e = 8'(seed + 8'(i - 14));
            else                   e = 8'h00;
            exp_q.push_back('{e, (i == n - 1), g, 0});
        end
        for (int i = 0; i < len; i++) begin
            if (ip) ip_src.push_back({(i == len - 1), 8'(seed + 8'(i))});
            else    arp_src.push_back({(i == len - 1), 8'(seed + 8'(i))});
        end
        return n;
    endfunction

    task automatic run_frames(input int budget, input bit scramble);
        int b = 0;
        while ((cap_q.size() < exp_q.size() || arp_src.size() > 0 || ip_src.size() > 0) && b < budget) begin
            step();
            b++;
            if (scramble && b == 2) begin
                arp_dst = 48'hBADBADBADBAD;
                ip_dst  = 48'hDEADDEADDEAD;
            end
        end
        check(b < budget, "frame_timeout", b, budget);
        repeat (3) step();
    endtask

    task automatic compare_stream(input string name);
        int bad = -1;
        int n;
        check(cap_q.size() == exp_q.size(), {name, "_len"}, cap_q.size(), exp_q.size());
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (bad < 0 && (cap_q[i].data !== exp_q[i].data || cap_q[i].last !== exp_q[i].last ||
                            cap_q[i].grant !== exp_q[i].grant))
                bad = i;
        if (bad < 0)
            check(1'b1, {name, "_bytes"}, 0, 0);
        else
            check(1'b0, $sformatf("%s_byte%0d", name, bad),
                  {cap_q[bad].grant, cap_q[bad].last, cap_q[bad].data},
                  {exp_q[bad].grant, exp_q[bad].last, exp_q[bad].data});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    initial begin
        int f0, cl, nlen;
        string nm;
        reset = 1'b1; local_mac = LOCAL_MAC; arp_dst = '1; ip_dst = '0;
        tx_tready = 1'b1;
        drive_src();
        vecs[0] = '{1'b0, 48'hFFFFFFFFFFFF, 28,  8'h01, 0, 42,  60,  16'h0806};
        vecs[1] = '{1'b1, 48'h021122334455, 100, 8'h10, 1, 114, 114, 16'h0800};
        vecs[2] = '{1'b1, 48'h021122334455, 100, 8'h10, 0, 114, 114, 16'h0800};
        vecs[3] = '{1'b0, 48'h0A0B0C0D0E0F, 1,   8'hAB, 0, 15,  60,  16'h0806};
        vecs[4] = '{1'b1, 48'h525400123456, 1,   8'hAB, 2, 15,  60,  16'h0800};
        vecs[5] = '{1'b1, 48'h112233445566, 46,  8'h80, 2, 60,  60,  16'h0800};
        vecs[6] = '{1'b0, 48'h0C0D0E0F1011, 45,  8'h40, 1, 59,  60,  16'h0806};

        do_reset();
        check({tx_tvalid, tx_tlast, tx_tdata, arp_tready, ip_tready, grant} === 14'h0,
              "reset_outputs", {tx_tvalid, tx_tlast, tx_tdata, arp_tready, ip_tready, grant}, 0);

        // Single frames from the table.
        for (int v = 0; v < 7; v++) begin
            cap_q.delete(); exp_q.delete();
            tr_mode = vecs[v].mode;
            if (vecs[v].ip) ip_dst = vecs[v].dst; else arp_dst = vecs[v].dst;
            void'(add_frame(vecs[v].ip, vecs[v].dst, vecs[v].len, vecs[v].seed));
            load_cyc = cyc;
            drive_src();
            run_frames(4000, 1'b1);
            nm = $sformatf("vec%0d", v);
            check(log_v[load_cyc] === 1'b0 && log_v[load_cyc + 1] === 1'b1, {nm, "_latency"},
                  {log_v[load_cyc], log_v[load_cyc + 1]}, 2'b01);
            compare_stream(nm);
`ifdef TX_ARB_PAD_EN
            nlen = vecs[v].exp_len_pad;
`else
            nlen = vecs[v].exp_len;
`endif
            check(cap_q.size() == nlen, {nm, "_frame_len"}, cap_q.size(), nlen);
            if (cap_q.size() >= 14)
                check({cap_q[12].data, cap_q[13].data} === vecs[v].etype, {nm, "_etype"},
                      {cap_q[12].data, cap_q[13].data}, vecs[v].etype);
            else
                check(1'b0, {nm, "_etype"}, cap_q.size(), 14);
        end

        // Tie after reset, then both sources keep requesting.
        tr_mode = 0;
        do_reset();
        cap_q.delete(); exp_q.delete();
        arp_dst = 48'hFFFFFFFFFFFF; ip_dst = 48'h0200DEADBEEF;
        f0 = add_frame(1'b0, arp_dst, 4, 8'h20);
        void'(add_frame(1'b1, ip_dst, 3, 8'h30));
        void'(add_frame(1'b0, arp_dst, 2, 8'h40));
        void'(add_frame(1'b1, ip_dst, 5, 8'h50));
        void'(add_frame(1'b1, ip_dst, 1, 8'h60));
        load_cyc = cyc;
        drive_src();
        run_frames(4000, 1'b0);
        check(log_v[load_cyc + 1] === 1'b1, "rr_latency", log_v[load_cyc + 1], 1);
        compare_stream("rr_order");
        if (cap_q.size() > f0) begin
            cl = cap_q[f0 - 1].cyc;
            check(cap_q[f0].cyc == cl + 2 && log_v[cl + 1] === 1'b0, "rr_idle_gap",
                  cap_q[f0].cyc - cl, 2);
            check({cap_q[f0 - 1].grant, log_g[cl + 1], cap_q[f0].grant} === 6'b01_00_10,
                  "rr_grant_seq", {cap_q[f0 - 1].grant, log_g[cl + 1], cap_q[f0].grant}, 6'b010010);
        end else begin
            check(1'b0, "rr_idle_gap", cap_q.size(), f0 + 1);
        end

        // Reset while header byte 7 is on the bus.
        cap_q.delete(); exp_q.delete();
        void'(add_frame(1'b0, arp_dst, 10, 8'h70));
        drive_src();
        for (int b = 0; b < 100 && cap_q.size() < 7; b++) step();
        check(cap_q.size() == 7, "rst_reach_byte7", cap_q.size(), 7);
        reset = 1'b1;
        arp_src.delete();
        drive_src();
        step();
        reset = 1'b0;
        check({tx_tvalid, tx_tlast, tx_tdata, arp_tready, grant} === 13'h0, "rst_midframe_outputs",
              {tx_tvalid, tx_tlast, tx_tdata, arp_tready, grant}, 0);
        cap_q.delete(); exp_q.delete();
        ip_dst = 48'h02AABBCCDDEE;
        void'(add_frame(1'b1, ip_dst, 3, 8'h90));
        drive_src();
        run_frames(4000, 1'b0);
        compare_stream("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks done", n_pass, n_chk);
        $fatal(1);
    end

endmodule
